// File: rtl/rpn_sequencer.sv
// RPN instruction sequencer: expands PUSH/ADD/SUB/MUL/DUP/DROP/SWAP into
// timed strobes for the hardware stack, tracking depth and sticky faults.
module rpn_sequencer #(
    parameter int unsigned MAX_DEPTH = 1023,
    parameter int unsigned DW        = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          instr_valid,
    output logic          instr_ready,
    input  logic [2:0]    instr_op,
    input  logic [DW-1:0] instr_imm,
    input  logic          clr_err,
    output logic          st_push,
    output logic          st_pop,
    output logic          st_write,
    output logic [DW-1:0] st_data,
    input  logic [DW-1:0] st_top,
    output logic [9:0]    depth,
    output logic          error,
    output logic [1:0]    err_code,
    output logic [15:0]   retired
);

    localparam int unsigned DEPTH_W = 10;
    localparam int unsigned RET_W   = 16;

    localparam logic [2:0] OP_NOP  = 3'd0;
    localparam logic [2:0] OP_PUSH = 3'd1;
    localparam logic [2:0] OP_ADD  = 3'd2;
    localparam logic [2:0] OP_SUB  = 3'd3;
    localparam logic [2:0] OP_MUL  = 3'd4;
    localparam logic [2:0] OP_DUP  = 3'd5;
    localparam logic [2:0] OP_DROP = 3'd6;
    localparam logic [2:0] OP_SWAP = 3'd7;

    // SETTLE_W settles before the WRITE of a binary op; SETTLE ends a sequence.
    typedef enum logic [3:0] {
        S_IDLE, S_DONE, S_PUSH, S_LATCH_A, S_POP,
        S_SETTLE_W, S_WRITE, S_PUSH_B, S_SETTLE
    } state_t;

    state_t               state_q;
    logic [2:0]           op_q;
    logic [DW-1:0]        imm_q;
    logic [DW-1:0]        a_q;
    logic [DW-1:0]        b_q;
    logic [DEPTH_W-1:0]   depth_q;
    logic                 error_q;
    logic [1:0]           err_code_q;
    logic [RET_W-1:0]     retired_q;

    logic                 accept_c;
    logic                 underflow_c;
    logic                 overflow_c;
    state_t               first_c;
    logic [DW-1:0]        result_c;

    assign instr_ready = (state_q == S_IDLE) && !rst;
    assign accept_c    = instr_valid && instr_ready;

    // Fault detection and first state of the sequence, judged at acceptance.
    always_comb begin
        underflow_c = 1'b0;
        overflow_c  = 1'b0;
        first_c     = S_DONE;
        case (instr_op)
            OP_PUSH: begin
                overflow_c = (depth_q == DEPTH_W'(MAX_DEPTH));
                first_c    = S_PUSH;
            end
            OP_DUP: begin
                underflow_c = (depth_q == '0);
                overflow_c  = (depth_q == DEPTH_W'(MAX_DEPTH));
                first_c     = S_PUSH;
            end
            OP_DROP: begin
                underflow_c = (depth_q == '0);
                first_c     = S_POP;
            end
            OP_ADD, OP_SUB, OP_MUL, OP_SWAP: begin
                underflow_c = (depth_q < DEPTH_W'(2));
                first_c     = S_LATCH_A;
            end
            default: first_c = S_DONE;
        endcase
        if (underflow_c || overflow_c) begin
            first_c = S_DONE;
        end
    end

    // WRITE payload: arithmetic result, or the old top when swapping.
    always_comb begin
        case (op_q)
            OP_ADD:  result_c = st_top + a_q;
            OP_SUB:  result_c = st_top - a_q;
            OP_MUL:  result_c = st_top * a_q;
            default: result_c = a_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            op_q       <= OP_NOP;
            imm_q      <= '0;
            a_q        <= '0;
            b_q        <= '0;
            depth_q    <= '0;
            error_q    <= 1'b0;
            err_code_q <= 2'd0;
            retired_q  <= '0;
        end else begin
            if (clr_err) begin
                error_q    <= 1'b0;
                err_code_q <= 2'd0;
            end
            case (state_q)
                S_IDLE: begin
                    if (accept_c) begin
                        op_q      <= instr_op;
                        imm_q     <= instr_imm;
                        retired_q <= retired_q + RET_W'(1);
                        state_q   <= first_c;
                        // A simultaneous clr_err loses to the new fault.
                        if (underflow_c || overflow_c) begin
                            error_q <= 1'b1;
                            if (err_code_q == 2'd0 || clr_err) begin
                                err_code_q <= underflow_c ? 2'd1 : 2'd2;
                            end
                        end
                    end
                end
                S_LATCH_A: begin
                    a_q     <= st_top;
                    state_q <= S_POP;
                end
                S_POP: begin
                    depth_q <= depth_q - DEPTH_W'(1);
                    state_q <= (op_q == OP_DROP) ? S_SETTLE : S_SETTLE_W;
                end
                S_SETTLE_W: state_q <= S_WRITE;
                S_WRITE: begin
                    if (op_q == OP_SWAP) begin
                        b_q     <= st_top;
                        state_q <= S_PUSH_B;
                    end else begin
                        state_q <= S_IDLE;
                    end
                end
                S_PUSH, S_PUSH_B: begin
                    depth_q <= depth_q + DEPTH_W'(1);
                    state_q <= S_SETTLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // Strobes and payload are pure decodes of the current state.
    always_comb begin
        st_push  = 1'b0;
        st_pop   = 1'b0;
        st_write = 1'b0;
        st_data  = '0;
        case (state_q)
            S_PUSH: begin
                st_push = 1'b1;
                st_data = (op_q == OP_DUP) ? st_top : imm_q;
            end
            S_PUSH_B: begin
                st_push = 1'b1;
                st_data = b_q;
            end
            S_POP: st_pop = 1'b1;
            S_WRITE: begin
                st_write = 1'b1;
                st_data  = result_c;
            end
            default: st_data = '0;
        endcase
    end

    assign depth    = depth_q;
    assign error    = error_q;
    assign err_code = err_code_q;
    assign retired  = retired_q;

endmodule

// File: doc/rpn_sequencer.md
Name: rpn_sequencer

Overview:
- Instruction-driven controller for the 16-bit hardware stack (1023-entry, push/pop/write strobes, registered second-of-stack read).
- Accepts RPN instructions over a valid/ready handshake and expands each one into a timed sequence of stack strobes.
- Covers PUSH, ADD, SUB, MUL, DUP, DROP and SWAP, with depth tracking and underflow/overflow detection.
- Sits between the front-end (switch/key decoder or program ROM) and the stack, replacing the ad-hoc add/mult FSM.

Parameters:
- MAX_DEPTH, 1023, stack capacity; PUSH/DUP at this depth is an overflow.
- DW, 16, data width of stack entries and immediates.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- instr_valid  in  1  instruction present
- instr_ready  out  1  sequencer can accept an instruction
- instr_op  in  3  opcode: 0 NOP, 1 PUSH, 2 ADD, 3 SUB, 4 MUL, 5 DUP, 6 DROP, 7 SWAP
- instr_imm  in  DW  immediate for PUSH
- clr_err  in  1  clears error and err_code
- st_push  out  1  stack push strobe
- st_pop  out  1  stack pop strobe
- st_write  out  1  stack overwrite-top strobe
- st_data  out  DW  data for push/write
- st_top  in  DW  current stack top
- depth  out  10  entries currently on stack
- error  out  1  sticky fault flag
- err_code  out  2  first fault: 0 none, 1 underflow, 2 overflow
- retired  out  16  count of accepted instructions, wraps at 65535->0

Behaviour:
- Reset values: state IDLE, depth 0, error 0, err_code 0, retired 0, latches a/b 0, all strobes 0, st_data 0. instr_ready is 0 while rst is high.
- instr_ready = (state==IDLE) && !rst. An instruction is accepted on a clk edge where valid && ready; opcode/imm are latched and retired increments.
- Strobes are decoded from state. At most one strobe is high per cycle. st_data is 0 whenever no push/write strobe is high.
- Each state lasts one cycle. SETTLE is mandatory after any pointer change, because the stack's second-entry read is registered. The sequence listed for each op starts on the cycle after acceptance; IDLE follows the last state.
  - NOP: DONE.
  - PUSH: PUSH(st_push, st_data=imm), SETTLE. depth+1.
  - ADD/SUB/MUL: LATCH_A(a<=st_top), POP(st_pop), SETTLE, WRITE(st_write, st_data=f). depth-1.
    - ADD: f = st_top+a.
    - SUB: f = st_top-a (second minus top).
    - MUL: f = st_top*a.
    - All results are truncated to the low DW bits (mod 2^16).
  - DUP: PUSH(st_data=st_top), SETTLE. depth+1.
  - DROP: POP, SETTLE. depth-1.
  - SWAP: LATCH_A, POP, SETTLE, WRITE(st_data=a, b<=st_top), PUSH(st_data=b), SETTLE. depth unchanged.
- depth updates on the same edge that ends the PUSH or POP state.
- Fault check at acceptance:
  - Underflow: depth<2 for ADD/SUB/MUL/SWAP, or depth<1 for DUP/DROP.
  - Overflow: depth==MAX_DEPTH for PUSH/DUP.
  - On a fault the op runs as DONE only (no strobes, depth unchanged) and retired still increments.
  - error is set. err_code is written only if it was 0, so it keeps the first fault.
- clr_err clears error and err_code in any state and does not disturb an op in flight. If a fault and clr_err occur on the same edge, the fault wins.
- rst mid-sequence aborts immediately: state IDLE, depth 0. The stack shares rst, so both are empty.
- instr_valid that drops while ready is low is ignored. No instruction buffering.

Test Plan:
- Reset, then PUSH 5, PUSH 7, ADD -> stack top 12, depth 1, retired 3. ADD takes 4 cycles from acceptance to ready.
- PUSH 10, PUSH 3, SUB -> top 7. PUSH 0x0100, PUSH 0x0100, MUL -> top 0x0000 (truncated).
- PUSH 1, PUSH 2, SWAP -> top 1, then DROP -> top 2, depth 1. Each strobe appears exactly once, in the order listed.
- Empty stack, DROP -> error 1, err_code 1, no strobes, depth 0. Then PUSH 4 succeeds with err_code still 1. clr_err -> error 0, err_code 0.
- Fill to 1023 with PUSH, then DUP -> err_code 2, no st_push, depth 1023.
- Assert rst during the SETTLE of an ADD -> next cycle depth 0, no strobes, instr_ready 1 after rst falls.
